mem_access_unit: RTL and testbench

Data-memory access sequencer sitting directly downstream of the multi-cycle control state machine. It consumes that controller's `mem_en` access window and `ra_mux` address select, and drives a single-port synchronous word memory. It performs instruction-address pass-through, aligned word stores, sub-word stores via read-modify-write, and sign/zero-extended loads, and flags misaligned accesses.

---
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Controller/memory bundle for mem_access_unit. mem_wstrb exists only when
// MEM_BYTE_STROBE_EN is defined.
interface mem_access_unit_if #(parameter int MEM_AW = 12);
   logic              mem_en;
   logic              ra_mux;
   logic [31:0]       pc;
   logic [31:0]       data_addr;
   logic [31:0]       wdata;
   logic [2:0]        funct3;
   logic              is_load;
   logic              is_store;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;
`ifdef MEM_BYTE_STROBE_EN
   logic [3:0]        mem_wstrb;
`endif
   logic [31:0]       mem_rdata;
   logic [31:0]       load_data;
   logic              done;
   logic              misaligned;

   modport slave (
      input  mem_en, ra_mux, pc, data_addr, wdata, funct3, is_load, is_store, mem_rdata,
      output mem_addr, mem_we, mem_wdata, load_data, done, misaligned
`ifdef MEM_BYTE_STROBE_EN
      , mem_wstrb
`endif
   );

   modport master (
      output mem_en, ra_mux, pc, data_addr, wdata, funct3, is_load, is_store, mem_rdata,
      input  mem_addr, mem_we, mem_wdata, load_data, done, misaligned
`ifdef MEM_BYTE_STROBE_EN
      , mem_wstrb
`endif
   );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: fetch reads, loads with extension, word and sub-word stores.
// Optional feature macro: MEM_BYTE_STROBE_EN (byte strobes replace read-modify-write).
module mem_access_unit #(
   parameter int MEM_AW = 12
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [1:0]  lane_r;
   logic [2:0]  funct3_r;
   logic        capture_r;
   logic [31:0] load_data_r;
   logic        done_r;
   logic        misaligned_r;

   logic [31:0] sel_s;
   logic [1:0]  lane_s;
   logic [1:0]  size_s;
   logic        data_access_s;
   logic        start_s;
   logic        bad_align_s;
   logic        load_en_s;
   logic        we_s;
   logic [31:0] wdata_s;
   logic        unused_addr_bits_s;
`ifdef MEM_BYTE_STROBE_EN
   logic [3:0]  wstrb_s;
`endif

   // size encoding from funct3[1:0]: 00 byte, 01 half, 1x word
   function automatic logic misaligned_addr(input logic [1:0] lane, input logic [1:0] size);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lane[0];
         default: return (lane != 2'b00);
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [2:0] f3);
      logic [31:0] sh;
      sh = rdata >> {lane, 3'b000};
      case (f3[1:0])
         2'b00:   return {{24{sh[7] & ~f3[2]}}, sh[7:0]};
         2'b01:   return {{16{sh[15] & ~f3[2]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] m;
      m = old;
      case (size)
         2'b00:   m[{lane, 3'b000} +: 8]        = wd[7:0];
         2'b01:   m[{lane[1], 4'b0000} +: 16]   = wd[15:0];
         default: m                             = wd;
      endcase
      return m;
   endfunction

`ifdef MEM_BYTE_STROBE_EN
   function automatic logic [3:0] byte_strobe(input logic [1:0] lane, input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] wd, input logic [1:0] size);
      case (size)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction
`endif

   assign sel_s              = bus.ra_mux ? bus.data_addr : bus.pc;
   assign lane_s             = sel_s[1:0];
   assign size_s             = bus.funct3[1:0];
   assign bus.mem_addr       = sel_s[MEM_AW+1:2];
   assign unused_addr_bits_s = ^sel_s[31:MEM_AW+2];
   assign data_access_s      = bus.ra_mux & (bus.is_load | bus.is_store);
   assign start_s            = (state_r == IDLE) & bus.mem_en;
   assign bad_align_s        = data_access_s & misaligned_addr(lane_s, size_s);

   // Next-state and memory write control
   always_comb begin
      next_state_s = state_r;
      we_s         = 1'b0;
      wdata_s      = 32'd0;
      load_en_s    = 1'b0;
`ifdef MEM_BYTE_STROBE_EN
      wstrb_s      = 4'b0000;
`endif
      case (state_r)
         IDLE: begin
            if (!bus.mem_en) begin
               next_state_s = IDLE;
            end else if (!data_access_s || bus.is_load) begin
               next_state_s = bad_align_s ? DONE : RD;
            end else if (bad_align_s) begin
               next_state_s = DONE;
            end else begin
`ifdef MEM_BYTE_STROBE_EN
               we_s         = 1'b1;
               wdata_s      = replicate(bus.wdata, size_s);
               wstrb_s      = byte_strobe(lane_s, size_s);
               next_state_s = DONE;
`else
               if (size_s[1]) begin
                  we_s         = 1'b1;
                  wdata_s      = bus.wdata;
                  next_state_s = DONE;
               end else begin
                  // read data for the merge arrives next cycle, so go straight to the write
                  next_state_s = WR;
               end
`endif
            end
         end
         RD: begin
            if (bus.mem_en) begin
               load_en_s    = capture_r;
               next_state_s = DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         WR: begin
            if (bus.mem_en) begin
               we_s         = 1'b1;
               wdata_s      = merge_store(bus.mem_rdata, bus.wdata, lane_r, funct3_r[1:0]);
               next_state_s = DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         DONE: begin
            if (bus.mem_en) begin
               next_state_s = DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, captured access attributes and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         lane_r       <= 2'b00;
         funct3_r     <= 3'b000;
         capture_r    <= 1'b0;
         load_data_r  <= 32'd0;
         done_r       <= 1'b0;
         misaligned_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         done_r  <= (next_state_s == DONE) && (state_r != DONE);
         if (start_s) begin
            lane_r       <= lane_s;
            funct3_r     <= bus.funct3;
            capture_r    <= data_access_s & bus.is_load;
            misaligned_r <= bad_align_s;
         end
         if (load_en_s) begin
            load_data_r <= extend_load(bus.mem_rdata, lane_r, funct3_r);
         end
      end
   end

   assign bus.mem_we     = we_s & ~rst;
   assign bus.mem_wdata  = rst ? 32'd0 : wdata_s;
`ifdef MEM_BYTE_STROBE_EN
   assign bus.mem_wstrb  = rst ? 4'b0000 : wstrb_s;
`endif
   assign bus.load_data  = load_data_r;
   assign bus.done       = done_r;
   assign bus.misaligned = misaligned_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random accesses
// against an arithmetic reference model of memory and load results.
module tb_mem_access_unit;
   localparam int MEM_AW = 12;
`ifdef MEM_BYTE_STROBE_EN
   localparam bit STROBES = 1'b1;
`else
   localparam bit STROBES = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mem_access_unit_if #(.MEM_AW(MEM_AW)) bus ();
   mem_access_unit #(.MEM_AW(MEM_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0]       tb_mem  [0:(1<<MEM_AW)-1];
   logic [31:0]       ref_mem [0:(1<<MEM_AW)-1];
   logic              poke_en;
   logic [MEM_AW-1:0] poke_addr;
   logic [31:0]       poke_data;
   logic [31:0]       exp_load;

   // synchronous single-port memory seen by the unit
   always @(posedge clk) begin
      if (poke_en) begin
         tb_mem[poke_addr] <= poke_data;
      end else if (bus.mem_we) begin
`ifdef MEM_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) tb_mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
`else
         tb_mem[bus.mem_addr] <= bus.mem_wdata;
`endif
      end
      bus.mem_rdata <= tb_mem[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] d);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = idx[MEM_AW-1:0];
      poke_data = d;
      @(negedge clk);
      poke_en      = 1'b0;
      ref_mem[idx] = d;
   endtask

   task automatic access(input logic ra, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic ld, input logic st, input int win);
      int idx, lane, size, exp_done, exp_wr, first_done, ndone, first_wr, nwr;
      logic data, mis;
      longint unsigned m, v;
      logic [31:0] word;
      idx      = int'((addr >> 2) % (1 << MEM_AW));
      lane     = int'(addr % 4);
      size     = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      data     = ra && (ld || st);
      mis      = data && ((lane % size) != 0);
      m        = (64'd1 << (8 * size)) - 64'd1;
      word     = ref_mem[idx];
      exp_done = -1;
      exp_wr   = -1;
      if (!data) begin
         if (win >= 2) exp_done = 2;
      end else if (mis) begin
         exp_done = 1;
      end else if (ld) begin
         if (win >= 2) begin
            exp_done = 2;
            v = ({32'd0, word} >> (8 * lane)) & m;
            if (!f3[2] && size < 4 && v >= (m + 64'd1) / 64'd2) v = v | ~m;
            exp_load = v[31:0];
         end
      end else begin
         v = ({32'd0, word} & ~(m << (8 * lane))) | (({32'd0, wd} & m) << (8 * lane));
         if (size == 4 || STROBES) begin
            exp_wr = 0; exp_done = 1; ref_mem[idx] = v[31:0];
         end else if (win >= 2) begin
            exp_wr = 1; exp_done = 2; ref_mem[idx] = v[31:0];
         end
      end

      @(negedge clk);
      bus.ra_mux    = ra;
      bus.pc        = ra ? $urandom : addr;
      bus.data_addr = ra ? addr : $urandom;
      bus.wdata     = wd;
      bus.funct3    = f3;
      bus.is_load   = ld;
      bus.is_store  = st;
      bus.mem_en    = 1'b1;
      first_done = -1; ndone = 0; first_wr = -1; nwr = 0;
      for (int k = 0; k < 7; k++) begin
         #1;
         if (bus.done)   begin ndone++; if (first_done < 0) first_done = k; end
         if (bus.mem_we) begin nwr++;   if (first_wr < 0)   first_wr = k;   end
         @(negedge clk);
         if (k + 1 >= win) bus.mem_en = 1'b0;
      end
      check("done_cycle", first_done, exp_done);
      check("done_count", ndone, (exp_done >= 0) ? 32'd1 : 32'd0);
      check("write_cycle", first_wr, exp_wr);
      check("write_count", nwr, (exp_wr >= 0) ? 32'd1 : 32'd0);
      check("mem_word", tb_mem[idx], ref_mem[idx]);
      check("load_data", bus.load_data, exp_load);
      check("misaligned", {31'd0, bus.misaligned}, {31'd0, mis});
   endtask

   initial begin
      logic [2:0] f3;
      int kind;
      rst = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = 32'd0; exp_load = 32'd0;
      bus.mem_en = 1'b0; bus.ra_mux = 1'b0; bus.pc = 32'd0; bus.data_addr = 32'd0;
      bus.wdata = 32'd0; bus.funct3 = 3'b000; bus.is_load = 1'b0; bus.is_store = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_load_data", bus.load_data, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
`ifdef MEM_BYTE_STROBE_EN
      check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
`endif
      for (int i = 0; i < 16; i++) poke(i, $urandom);

      poke(32'h40, 32'h80FF_1234);
      access(1'b1, 32'h0000_0103, 32'd0, 3'b000, 1'b1, 1'b0, 2);
      check("lb_value", bus.load_data, 32'hFFFF_FF80);
      access(1'b1, 32'h0000_0103, 32'd0, 3'b100, 1'b1, 1'b0, 2);
      check("lbu_value", bus.load_data, 32'h0000_0080);
      access(1'b1, 32'h0000_0102, 32'd0, 3'b101, 1'b1, 1'b0, 2);
      check("lhu_value", bus.load_data, 32'h0000_80FF);

      poke(16, 32'h1122_3344);
      access(1'b1, 32'h0000_0041, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 2);
      check("sb_word", tb_mem[16], 32'h1122_AB44);

      access(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 2);
      check("sw_word", tb_mem[2], 32'hDEAD_BEEF);
      access(1'b1, 32'h0000_0008, 32'd0, 3'b010, 1'b1, 1'b0, 2);
      check("lw_value", bus.load_data, 32'hDEAD_BEEF);

      access(1'b1, 32'h0000_0005, 32'h0000_5555, 3'b001, 1'b0, 1'b1, 2);
      check("sh_misaligned", {31'd0, bus.misaligned}, 32'd1);
      access(1'b0, 32'h0000_0008, 32'd0, 3'b010, 1'b0, 1'b0, 2);
      check("flag_cleared", {31'd0, bus.misaligned}, 32'd0);

      access(1'b1, 32'h0000_0041, 32'h0000_00EE, 3'b000, 1'b0, 1'b1, 1);

`ifndef MEM_BYTE_STROBE_EN
      @(negedge clk);
      bus.ra_mux = 1'b1; bus.data_addr = 32'h0000_0041; bus.wdata = 32'h0000_00CD;
      bus.funct3 = 3'b000; bus.is_store = 1'b1; bus.is_load = 1'b0; bus.mem_en = 1'b1;
      @(negedge clk);
      #1;
      check("rmw_we_before_rst", {31'd0, bus.mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_we_async", {31'd0, bus.mem_we}, 32'd0);
      @(negedge clk);
      bus.mem_en = 1'b0;
      rst = 1'b0;
      exp_load = 32'd0;
      #1;
      check("rst_rmw_word", tb_mem[16], ref_mem[16]);
      check("rst_rmw_load_data", bus.load_data, 32'd0);
      check("rst_rmw_done", {31'd0, bus.done}, 32'd0);
      check("rst_rmw_wdata", bus.mem_wdata, 32'd0);
      check("rst_rmw_misaligned", {31'd0, bus.misaligned}, 32'd0);
`endif

      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         kind = $urandom_range(0, 3);
         a = ($urandom_range(0, 262143) << 14) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         f3 = 3'($urandom_range(0, 7));
         if (kind == 3 && f3[2] && !f3[1]) f3[2] = 1'b0;
         case (kind)
            0:       access(1'b0, a, $urandom, f3, 1'($urandom_range(0, 1)), 1'b0, 2);
            1:       access(1'b1, a, $urandom, f3, 1'b0, 1'b0, 2);
            2:       access(1'b1, a, $urandom, f3, 1'b1, 1'b0, ($urandom_range(0, 4) == 0) ? 1 : 2);
            default: access(1'b1, a, $urandom, f3, 1'b0, 1'b1, ($urandom_range(0, 4) == 0) ? 1 : 2);
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
